keypad_scan: RTL and testbench

//  4x4 matrix keypad scanner and debouncer; upstream stage of the calculator digit register.

---
 rtl/keypad_scan_if.sv | 11 +
 rtl/keypad_scan.sv | 154 +++++++++++++++
 tb/tb_keypad_scan.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Keypad-side signal bundle: column drive, row sense and the debounced key code.
// master = scanner, slave = keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [4:0] key_value;
  logic       key_valid;

  modport master (input row_in, output col_out, output key_value, output key_valid);
  modport slave  (output row_in, input col_out, input key_value, input key_valid);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce; holds the key code for the whole press.
// state    | meaning
// SCAN     | stepping columns each tick, looking for any low row
// DEBOUNCE | column frozen, counting stable ticks of the candidate row
// HOLD     | key accepted, key_value held while the row stays low
// RELEASE  | counting idle ticks before returning key_value to IDLE_CODE
module keypad_scan #(
  parameter int         CLK_DIV        = 50000,
  parameter int         DEBOUNCE_TICKS = 10,
  parameter logic [4:0] IDLE_CODE      = 5'd17
) (
  input logic          clk,
  input logic          rest,
  keypad_scan_if.master kp
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div;
  logic [3:0]       rows_m, rows_s;
  logic [1:0]       col, col_n;
  logic [1:0]       cand_row, cand_row_n;
  logic [1:0]       cand_col, cand_col_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [4:0]       key_value, key_value_n;
  logic             key_valid, key_valid_n;
  logic             tick, hit;
  logic [1:0]       low_row;

  assign tick    = (div == DIV_LAST);
  assign hit     = (rows_s != 4'b1111);
  assign cnt_inc = cnt + CNT_ONE;

  always_comb begin
    low_row = 2'd3;
    if      (!rows_s[0]) low_row = 2'd0;
    else if (!rows_s[1]) low_row = 2'd1;
    else if (!rows_s[2]) low_row = 2'd2;
  end

  always_comb begin
    state_n     = state;
    col_n       = col;
    cand_row_n  = cand_row;
    cand_col_n  = cand_col;
    cnt_n       = cnt;
    key_value_n = key_value;
    key_valid_n = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (hit) begin
            cand_row_n = low_row;
            cand_col_n = col;
            if (DEBOUNCE_TICKS == 1) begin
              state_n     = HOLD;
              cnt_n       = '0;
              key_value_n = {1'b0, low_row, col};
              key_valid_n = 1'b1;
            end else begin
              state_n = DEBOUNCE;
              cnt_n   = CNT_ONE;
            end
          end else begin
            col_n = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (hit && (low_row == cand_row)) begin
            if (cnt_inc == CNT_MAX) begin
              state_n     = HOLD;
              cnt_n       = '0;
              key_value_n = {1'b0, cand_row, cand_col};
              key_valid_n = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            // column stays put so the same column is rescanned on the next tick
            state_n = SCAN;
            cnt_n   = '0;
          end
        end
        HOLD: begin
          if (!hit) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_n     = SCAN;
              cnt_n       = '0;
              col_n       = col + 2'd1;
              key_value_n = IDLE_CODE;
            end else begin
              state_n = RELEASE;
              cnt_n   = CNT_ONE;
            end
          end
        end
        RELEASE: begin
          if (!hit) begin
            if (cnt_inc == CNT_MAX) begin
              state_n     = SCAN;
              cnt_n       = '0;
              col_n       = col + 2'd1;
              key_value_n = IDLE_CODE;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = HOLD;
            cnt_n   = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      state     <= SCAN;
      div       <= '0;
      rows_m    <= 4'b1111;
      rows_s    <= 4'b1111;
      col       <= 2'd0;
      cand_row  <= 2'd0;
      cand_col  <= 2'd0;
      cnt       <= '0;
      key_value <= IDLE_CODE;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= tick ? '0 : div + DIV_W'(1);
      rows_m    <= kp.row_in;
      rows_s    <= rows_m;
      col       <= col_n;
      cand_row  <= cand_row_n;
      cand_col  <= cand_col_n;
      cnt       <= cnt_n;
      key_value <= key_value_n;
      key_valid <= key_valid_n;
    end
  end

  assign kp.col_out   = ~(4'b0001 << col);
  assign kp.key_value = key_value;
  assign kp.key_valid = key_valid;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad model shorts driven columns to rows, and a
// scoreboard monitor checks every key_value change / key_valid pulse against queued expectations.
module tb_keypad_scan;
  logic clk = 1'b0;
  logic rest = 1'b0;
  logic [15:0] keys = '0;

  keypad_scan_if kif ();

  keypad_scan #(.CLK_DIV(4), .DEBOUNCE_TICKS(3), .IDLE_CODE(5'd17)) dut (
    .clk  (clk),
    .rest (rest),
    .kp   (kif.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++)
      kif.row_in[r] = ~|(keys[r*4 +: 4] & ~kif.col_out);
  end

  typedef struct packed {
    logic [4:0] v;
    logic       vld;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         nvec = 0;
  int         nfail = 0;
  logic       mon_en = 1'b0;
  logic [4:0] last_kv = 5'd17;
  int         n;

  always @(negedge clk) begin
    if (mon_en && (kif.key_value !== last_kv || kif.key_valid !== 1'b0)) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_output: key_value=%0d key_valid=%0b, nothing expected",
                 kif.key_value, kif.key_valid);
      end else begin
        e = exp_q.pop_front();
        if (kif.key_value !== e.v || kif.key_valid !== e.vld) begin
          nfail++;
          $display("FAIL scoreboard: got key_value=%0d key_valid=%0b, want key_value=%0d key_valid=%0b",
                   kif.key_value, kif.key_valid, e.v, e.vld);
        end
      end
      last_kv = kif.key_value;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int c);
    repeat (c) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] v, input int budget, output int cyc);
    cyc = 0;
    while (kif.col_out !== v && cyc < budget) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (kif.col_out !== v) begin
      nvec++;
      nfail++;
      $display("FAIL wait_col timeout: col_out=%b, want %b", kif.col_out, v);
    end
  endtask

  task automatic wait_kv(input logic [4:0] v, input int budget, output int cyc);
    cyc = 0;
    while (kif.key_value !== v && cyc < budget) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (kif.key_value !== v) begin
      nvec++;
      nfail++;
      $display("FAIL wait_kv timeout: key_value=%0d, want %0d", kif.key_value, v);
    end
  endtask

  task automatic push(input logic [4:0] v, input logic vld);
    exp_t x;
    x.v   = v;
    x.vld = vld;
    exp_q.push_back(x);
  endtask

  initial begin
    // 1: reset and idle column stepping
    clocks(2);
    check("rst_col", 32'(kif.col_out), 32'hE);
    check("rst_kv", 32'(kif.key_value), 32'd17);
    check("rst_valid", 32'(kif.key_valid), 32'd0);
    last_kv = 5'd17;
    mon_en  = 1'b1;
    rest    = 1'b1;
    wait_col(4'b1101, 20, n); check("step_1101", n, 4);
    wait_col(4'b1011, 20, n); check("step_1011", n, 4);
    wait_col(4'b0111, 20, n); check("step_0111", n, 4);
    wait_col(4'b1110, 20, n); check("step_1110", n, 4);

    // 2: clean press row2/col1
    wait_col(4'b1101, 20, n);
    push(5'd9, 1'b1);
    keys[9] = 1'b1;
    wait_kv(5'd9, 40, n); check("press_latency", n, 12);
    clocks(20);
    check("hold_col", 32'(kif.col_out), 32'hD);
    check("hold_kv", 32'(kif.key_value), 32'd9);
    clocks(20);
    push(5'd17, 1'b0);
    keys[9] = 1'b0;
    wait_kv(5'd17, 40, n);
    check("release_col_next", 32'(kif.col_out), 32'hB);

    // 3: bounce on press, then stable press
    wait_col(4'b1101, 40, n);
    keys[9] = 1'b1;
    clocks(4);
    keys[9] = 1'b0;
    clocks(4);
    check("bounce_col_kept", 32'(kif.col_out), 32'hD);
    check("bounce_kv_idle", 32'(kif.key_value), 32'd17);
    push(5'd9, 1'b1);
    keys[9] = 1'b1;
    wait_kv(5'd9, 40, n); check("repress_latency", n, 12);

    // 4: bounce on release
    clocks(4);
    keys[9] = 1'b0;
    clocks(4);
    keys[9] = 1'b1;
    clocks(4);
    push(5'd17, 1'b0);
    keys[9] = 1'b0;
    clocks(8);
    check("rel_bounce_held", 32'(kif.key_value), 32'd9);
    clocks(4);
    check("rel_bounce_idle", 32'(kif.key_value), 32'd17);

    // 5: two keys in one column, then a key in another column during HOLD
    wait_col(4'b1110, 40, n);
    push(5'd4, 1'b1);
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    wait_kv(5'd4, 40, n); check("two_key_latency", n, 12);
    keys[2] = 1'b1;
    clocks(20);
    check("second_key_ignored", 32'(kif.key_value), 32'd4);
    check("second_key_col", 32'(kif.col_out), 32'hE);
    push(5'd17, 1'b0);
    keys = '0;
    wait_kv(5'd17, 40, n);
    check("two_key_release_col", 32'(kif.col_out), 32'hD);

    // 6: reset while holding key 13
    wait_col(4'b1101, 40, n);
    push(5'd13, 1'b1);
    keys[13] = 1'b1;
    wait_kv(5'd13, 40, n); check("key13_latency", n, 12);
    clocks(5);
    push(5'd17, 1'b0);
    rest = 1'b0;
    clocks(1);
    check("hold_rst_kv", 32'(kif.key_value), 32'd17);
    check("hold_rst_col", 32'(kif.col_out), 32'hE);
    check("hold_rst_valid", 32'(kif.key_valid), 32'd0);
    keys = '0;
    clocks(1);
    rest = 1'b1;
    wait_col(4'b1101, 20, n); check("post_rst_scan", n, 4);
    check("post_rst_kv", 32'(kif.key_value), 32'd17);

    clocks(4);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
